// File: rtl/mmio_bridge.sv
// Splits core data-memory accesses between data memory and an MMIO register window (cycle counter, GPIO, console TX FIFO).
// Reads return one cycle after the access from either target; the TX FIFO drains on TxValid & TxReady and drops pushes when full.
module mmio_bridge #(
  parameter int          BIT_COUNT     = 32,
  parameter logic [31:0] MMIO_BASE     = 32'hFFFF_F000,
  parameter int          TX_FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemEn,
  input  logic                   MemWriteEn,
  input  logic [BIT_COUNT/8-1:0] MemByteEn,
  input  logic [BIT_COUNT-1:0]   MemAdr,
  input  logic [BIT_COUNT-1:0]   MemWriteData,
  output logic [BIT_COUNT-1:0]   MemReadData,
  output logic                   DMemEn,
  output logic                   DMemWriteEn,
  output logic [BIT_COUNT/8-1:0] DMemByteEn,
  output logic [BIT_COUNT-1:0]   DMemAdr,
  output logic [BIT_COUNT-1:0]   DMemWriteData,
  input  logic [BIT_COUNT-1:0]   DMemReadData,
  output logic [BIT_COUNT-1:0]   GpioOut,
  output logic                   TxValid,
  output logic [7:0]             TxData,
  input  logic                   TxReady
);
  localparam int NB = BIT_COUNT / 8;
  localparam int SH = $clog2(NB);
  localparam int AW = $clog2(TX_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [BIT_COUNT-1:0] BASE = BIT_COUNT'(MMIO_BASE);

  logic                 sel, acc, sel_q;
  logic [11:0]          idx;
  logic [BIT_COUNT-1:0] cycle_cnt, rdata, prd_q;
  logic [7:0]           mem [TX_FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 overflow, full, empty;
  logic                 push_req, push_ok, pop, ovf_clr;

  assign sel = MemEn & (MemAdr[BIT_COUNT-1:12] == BASE[BIT_COUNT-1:12]);
  assign acc = sel & ~reset;
  assign idx = 12'(MemAdr[11:0] >> SH);

  assign DMemEn        = MemEn & ~sel;
  assign DMemWriteEn   = MemWriteEn;
  assign DMemByteEn    = MemByteEn;
  assign DMemAdr       = MemAdr;
  assign DMemWriteData = MemWriteData;

  assign full     = (count == CW'(TX_FIFO_DEPTH));
  assign empty    = (count == '0);
  assign TxValid  = ~empty;
  assign TxData   = TxValid ? mem[rd_ptr] : 8'h00;
  assign pop      = TxValid & TxReady;
  assign push_req = acc & MemWriteEn & (idx == 12'd2) & MemByteEn[0];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req & (~full | pop);
  assign ovf_clr  = acc & MemWriteEn & (idx == 12'd3) & MemByteEn[0] & MemWriteData[2];

  always_comb begin
    rdata = '0;
    case (idx)
      12'd0: rdata = cycle_cnt;
      12'd1: rdata = GpioOut;
      12'd3: begin
        rdata[0]    = full;
        rdata[1]    = empty;
        rdata[2]    = overflow;
        rdata[15:8] = 8'(count);
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      GpioOut   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      sel_q     <= 1'b0;
      prd_q     <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      sel_q     <= sel;
      prd_q     <= (acc & ~MemWriteEn) ? rdata : '0;
      if (acc & MemWriteEn & (idx == 12'd1)) begin
        for (int b = 0; b < NB; b++) begin
          if (MemByteEn[b]) GpioOut[8*b +: 8] <= MemWriteData[8*b +: 8];
        end
      end
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
      // Set beats clear when both land in the same cycle.
      if (push_req & full & ~pop) overflow <= 1'b1;
      else if (ovf_clr)           overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= MemWriteData[7:0];
  end

  assign MemReadData = sel_q ? prd_q : DMemReadData;
endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: decode, pass-through, register map, TX FIFO edges and reset.
module tb_mmio_bridge;
  logic        clk = 1'b0;
  logic        reset;
  logic        MemEn, MemWriteEn;
  logic [3:0]  MemByteEn;
  logic [31:0] MemAdr, MemWriteData, MemReadData;
  logic        DMemEn, DMemWriteEn;
  logic [3:0]  DMemByteEn;
  logic [31:0] DMemAdr, DMemWriteData;
  logic [31:0] DMemReadData = 32'h0;
  logic [31:0] GpioOut;
  logic        TxValid, TxReady;
  logic [7:0]  TxData;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] A_CYC  = 32'hFFFF_F000;
  localparam logic [31:0] A_GPIO = 32'hFFFF_F004;
  localparam logic [31:0] A_TX   = 32'hFFFF_F008;
  localparam logic [31:0] A_STAT = 32'hFFFF_F00C;

  logic [31:0] dmem [256];

  mmio_bridge dut (
    .clk(clk), .reset(reset), .MemEn(MemEn), .MemWriteEn(MemWriteEn),
    .MemByteEn(MemByteEn), .MemAdr(MemAdr), .MemWriteData(MemWriteData),
    .MemReadData(MemReadData), .DMemEn(DMemEn), .DMemWriteEn(DMemWriteEn),
    .DMemByteEn(DMemByteEn), .DMemAdr(DMemAdr), .DMemWriteData(DMemWriteData),
    .DMemReadData(DMemReadData), .GpioOut(GpioOut), .TxValid(TxValid),
    .TxData(TxData), .TxReady(TxReady)
  );

  always #5 clk = ~clk;

  // Behavioural data memory with one-cycle synchronous read.
  always @(posedge clk) begin
    if (DMemEn) begin
      DMemReadData <= dmem[DMemAdr[9:2]];
      if (DMemWriteEn) dmem[DMemAdr[9:2]] <= DMemWriteData;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] be);
    MemEn = 1'b1; MemWriteEn = we; MemAdr = adr; MemWriteData = dat; MemByteEn = be;
  endtask

  task automatic idle();
    MemEn = 1'b0; MemWriteEn = 1'b0; MemByteEn = 4'h0; MemAdr = 32'h0; MemWriteData = 32'h0;
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] d);
    bus(1'b0, adr, 32'h0, 4'h0);
    tick();
    idle();
    #1;
    d = MemReadData;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  exp_bytes [8];
    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    reset = 1'b1;
    TxReady = 1'b0;
    idle();
    repeat (3) tick();

    chk("rst_gpio", GpioOut, 32'h0);
    chk("rst_txvalid", {31'h0, TxValid}, 32'h0);
    chk("rst_txdata", {24'h0, TxData}, 32'h0);
    chk("rst_rdata", MemReadData, DMemReadData);

    // CYCLE read ten cycles after reset release
    reset = 1'b0;
    repeat (10) tick();
    bus(1'b0, A_CYC, 32'h0, 4'h0);
    #1;
    chk("cyc_dmemen", {31'h0, DMemEn}, 32'h0);
    tick();
    idle();
    #1;
    chk("cyc_read", MemReadData, 32'd10);

    rd(A_STAT, d);
    chk("stat_reset", d, 32'h0000_0002);

    // GPIO byte-lane write
    bus(1'b1, A_GPIO, 32'hAABB_CCDD, 4'b0101);
    tick();
    idle();
    chk("gpio_out", GpioOut, 32'h00BB_00DD);
    rd(A_GPIO, d);
    chk("gpio_read", d, 32'h00BB_00DD);
    rd(A_TX, d);
    chk("txdata_read0", d, 32'h0);
    rd(32'hFFFF_F7FC, d);
    chk("unmapped_read0", d, 32'h0);

    // Overfill the FIFO with the consumer stalled
    for (int i = 1; i <= 9; i++) begin
      bus(1'b1, A_TX, i, 4'b0001);
      if (i == 1) begin
        #1;
        chk("no_fallthru", {31'h0, TxValid}, 32'h0);
      end
      tick();
    end
    idle();
    chk("head_valid", {31'h0, TxValid}, 32'h1);
    chk("head_data", {24'h0, TxData}, 32'h01);
    rd(A_STAT, d);
    chk("stat_full_ovf", d, 32'h0000_0805);
    chk("stall_hold", {24'h0, TxData}, 32'h01);

    TxReady = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_%0d", i), {23'h0, TxValid, TxData}, {23'h0, 1'b1, 8'(i)});
      tick();
    end
    TxReady = 1'b0;
    chk("drained_valid", {31'h0, TxValid}, 32'h0);
    rd(A_STAT, d);
    chk("stat_empty_ovf", d, 32'h0000_0006);
    bus(1'b1, A_STAT, 32'h0000_0004, 4'b0001);
    tick();
    idle();
    rd(A_STAT, d);
    chk("stat_ovf_clr", d, 32'h0000_0002);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      bus(1'b1, A_TX, 32'h11 + i, 4'b0001);
      tick();
    end
    idle();
    rd(A_STAT, d);
    chk("stat_full", d, 32'h0000_0801);
    bus(1'b1, A_TX, 32'h55, 4'b0001);
    TxReady = 1'b1;
    tick();
    TxReady = 1'b0;
    idle();
    rd(A_STAT, d);
    chk("stat_pushpop", d, 32'h0000_0801);
    exp_bytes = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h55};
    TxReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pp_drain_%0d", i), {23'h0, TxValid, TxData}, {23'h0, 1'b1, exp_bytes[i]});
      tick();
    end
    TxReady = 1'b0;
    rd(A_STAT, d);
    chk("stat_pp_empty", d, 32'h0000_0002);

    // Data-memory pass-through interleaved with an MMIO read
    bus(1'b1, 32'h40, 32'h1234_5678, 4'hF);
    #1;
    chk("dm_en_w", {31'h0, DMemEn}, 32'h1);
    chk("dm_we", {31'h0, DMemWriteEn}, 32'h1);
    chk("dm_be", {28'h0, DMemByteEn}, 32'hF);
    chk("dm_adr", DMemAdr, 32'h40);
    chk("dm_wdat", DMemWriteData, 32'h1234_5678);
    tick();
    bus(1'b0, 32'h40, 32'h0, 4'hF);
    #1;
    chk("dm_en_r", {31'h0, DMemEn}, 32'h1);
    chk("dm_we_r", {31'h0, DMemWriteEn}, 32'h0);
    tick();
    bus(1'b0, A_GPIO, 32'h0, 4'h0);
    #1;
    chk("ret_dmem", MemReadData, 32'h1234_5678);
    chk("mmio_no_dmem", {31'h0, DMemEn}, 32'h0);
    tick();
    idle();
    #1;
    chk("ret_mmio", MemReadData, 32'h00BB_00DD);

    // Reset with bytes queued; access during reset has no effect
    for (int i = 0; i < 3; i++) begin
      bus(1'b1, A_TX, 32'hA0 + i, 4'b0001);
      tick();
    end
    idle();
    chk("pre_rst_valid", {31'h0, TxValid}, 32'h1);
    reset = 1'b1;
    bus(1'b1, A_GPIO, 32'hFFFF_FFFF, 4'hF);
    tick();
    reset = 1'b0;
    idle();
    chk("post_rst_valid", {31'h0, TxValid}, 32'h0);
    chk("post_rst_gpio", GpioOut, 32'h0);
    rd(A_STAT, d);
    chk("post_rst_stat", d, 32'h0000_0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
